line_mem_ctrl: RTL and testbench
================================

LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_RANGE, default 256: number of 256-bit lines stored.
REQ-002 SHALL have parameter RD_LAT, default 4: cycles from read acceptance into an empty queue to valid; legal range 2..15.
REQ-003 SHALL have parameter QDEPTH, default 4: request queue entries, power of 2.
REQ-004 SHALL have port master_clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port a, input, 32: byte address; line index = a[12:5], word = a[4:2].
REQ-007 SHALL have port read, input, 1: line read request.
REQ-008 SHALL have port write, input, 1: line write request.
REQ-009 SHALL have port wd, input, 256: write line data; in bypass mode, word data is wd[31:0].
REQ-010 SHALL have port be, input, 4: byte enables for bypass word writes; ignored otherwise.
REQ-011 SHALL have port bypass, input, 1: when high, a write updates only 32-bit word a[4:2].
REQ-012 SHALL have port ready, output, 1: request can be accepted this cycle.
REQ-013 SHALL have port rd, output, 256: read line data.
REQ-014 SHALL have port valid, output, 1: one-cycle pulse marking rd as valid.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on a bad request.

Function
REQ-016 SHALL accept a request when (read|write)&ready; a, wd, be and bypass are captured into the queue on the same edge.
REQ-017 SHALL drive ready = !queue_full; a request presented while ready=0 is ignored, with no error.
REQ-018 SHALL treat read&write in the same cycle as a write only and pulse err the next cycle.
REQ-019 SHALL treat a[31:13]!=0 or line index>=MEM_RANGE as out-of-range: a write is dropped; a read returns rd=0 with valid and err pulsed together.
REQ-020 SHALL process queued requests strictly in order with FSM states IDLE, WR, RD_WAIT, RESP.
REQ-021 SHALL transition IDLE->WR on a queued write at head; WR commits the array in 1 cycle, pops, then goes to IDLE.
REQ-022 SHALL transition IDLE->RD_WAIT on a queued read at head and load a counter with RD_LAT-2.
REQ-023 SHALL decrement the counter in RD_WAIT and move to RESP when it reaches 0.
REQ-024 SHALL, in RESP, register rd with array[line], pulse valid, pop the queue and return to IDLE.
REQ-025 SHALL deliver valid exactly RD_LAT cycles after acceptance for a read accepted into an empty, idle controller.
REQ-026 SHALL let a read following a write to the same line observe the written data, because ordering is by queue.
REQ-027 SHALL, for a bypass write, update bytes of word a[4:2] whose be bit is 1 and leave all other bits unchanged.
REQ-028 SHALL hold rd at its last response value between valid pulses.
REQ-029 SHALL handle queue pointers modulo QDEPTH with an explicit count; push and pop in the same cycle leave the count unchanged and are legal when full.

Reset
REQ-030 SHALL, on reset, force: queue empty, FSM IDLE, counter 0, valid=0, err=0, rd=0, ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL discard in-flight and queued requests on reset mid-operation with no valid pulse; array contents are not reset.

Structure
REQ-032 SHALL place LINE_W=256, IDX_LSB=5, IDX_MSB=12, the FSM state encodings and the request-record field widths in shared package mm_pkg.
REQ-033 SHALL implement the queue as sub-module req_fifo (push/pop/full/empty/count, parameterised width and depth).
REQ-034 SHALL keep the storage array, FSM and latency counter in line_mem_ctrl itself.

Verification
REQ-035 SHALL verify: write line 3 = {8{32'hA5A5_0003}}, then read a=32'h60 -> valid exactly RD_LAT cycles after read acceptance, rd = the written line.
REQ-036 SHALL verify: 5 back-to-back reads while idle, QDEPTH=4 -> ready low after 4th acceptance, 5th ignored, 4 valids in order with zero err.
REQ-037 SHALL verify: line 1 all-zero, bypass write a=32'h2C, wd[31:0]=32'h1122_3344, be=4'b0101 -> read line 1 gives word 3 = 32'h0022_0044, others 0.
REQ-038 SHALL verify: read a=32'h0000_2000 -> valid and err pulse together, rd=0; write to same address -> err only, array unchanged.
REQ-039 SHALL verify: read&write same cycle to line 7 -> err pulse, line 7 updated, no valid.
REQ-040 SHALL verify: reset asserted while in RD_WAIT -> no valid for that read, ready=1 and rd=0 one cycle after reset deassert.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants, FSM encoding and request record for the line memory controller.
package mm_pkg;

    localparam int LINE_W  = 256;
    localparam int IDX_LSB = 5;
    localparam int IDX_MSB = 12;
    localparam int ADDR_W  = 32;
    localparam int BE_W    = 4;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // One queued request; read&write collapses to is_wr=1.
    typedef struct packed {
        logic              is_wr;
        logic              bypass;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] wd;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // Address is legal when the high bits are clear and the line exists.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int mem_range);
        logic [31:0] idx;
        idx = 32'(a[IDX_MSB:IDX_LSB]);
        return (a[ADDR_W-1:IDX_MSB+1] == '0) && (idx < 32'(mem_range));
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Small in-order request queue with explicit occupancy count.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       master_clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is fine as long as the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge master_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// Queued 256-bit line memory with fixed read latency and bypass word writes.
module line_mem_ctrl
    import mm_pkg::*;
#(
    parameter int MEM_RANGE = 256,
    parameter int RD_LAT    = 4,
    parameter int QDEPTH    = 4
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic [31:0]       a,
    input  logic              read,
    input  logic              write,
    input  logic [255:0]      wd,
    input  logic [3:0]        be,
    input  logic              bypass,
    output logic              ready,
    output logic [255:0]      rd,
    output logic              valid,
    output logic              err
);

    localparam int CW = $clog2(QDEPTH+1);

    logic [LINE_W-1:0] mem [0:MEM_RANGE-1];

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              accept, conflict;
    logic              fsm_pop, load_cnt, dec_cnt, resp;
    logic              q_full, q_empty;
    logic [CW-1:0]     q_count;
    logic [REQ_W-1:0]  q_dout;
    req_t              in_req, head;
    logic [7:0]        line_idx;
    logic [7:0]        word_off;
    logic              head_ok;

    assign ready    = !q_full;
    assign accept   = (read || write) && ready;
    assign conflict = accept && read && write;

    assign in_req   = '{is_wr: write, bypass: bypass, be: be, a: a, wd: wd};
    assign head     = req_t'(q_dout);
    assign line_idx = head.a[IDX_MSB:IDX_LSB];
    assign word_off = {head.a[4:2], 5'b0};
    assign head_ok  = addr_ok(head.a, MEM_RANGE);

    req_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_q (
        .master_clk (master_clk),
        .reset      (reset),
        .push       (accept),
        .pop        (fsm_pop && !q_empty),
        .din        (in_req),
        .dout       (q_dout),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    // FSM state register.
    always_ff @(posedge master_clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and per-state strobes; RD_WAIT exits straight into a registered response.
    always_comb begin
        next_state = state;
        fsm_pop    = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        resp       = 1'b0;
        case (state)
            IDLE: begin
                if (q_count != '0) begin
                    next_state = head.is_wr ? WR : RD_WAIT;
                    load_cnt   = !head.is_wr;
                end
            end
            WR: begin
                fsm_pop    = 1'b1;
                next_state = IDLE;
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    resp       = 1'b1;
                    next_state = RESP;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            RESP: begin
                fsm_pop    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latency counter and registered response outputs.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            cnt   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            rd    <= '0;
        end else begin
            if (load_cnt)     cnt <= CNT_W'(RD_LAT - 2);
            else if (dec_cnt) cnt <= cnt - 1'b1;
            valid <= resp;
            err   <= conflict || ((state == WR) && !head_ok) || (resp && !head_ok);
            if (resp) rd <= head_ok ? mem[line_idx] : '0;
        end
    end

    // Array commit: full line, or byte-masked single word in bypass mode.
    always_ff @(posedge master_clk) begin
        if (!reset && state == WR && head_ok) begin
            if (head.bypass) begin
                for (int b = 0; b < BE_W; b++)
                    if (head.be[b]) mem[line_idx][int'(word_off) + b*8 +: 8] <= head.wd[b*8 +: 8];
            end else begin
                mem[line_idx] <= head.wd;
            end
        end
    end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench for line_mem_ctrl: stimulus pushes expected responses, monitor checks them.
module tb_line_mem_ctrl;

    localparam int RD_LAT = 4;

    logic         master_clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a = '0;
    logic         read = 1'b0, write = 1'b0;
    logic [255:0] wd = '0;
    logic [3:0]   be = '0;
    logic         bypass = 1'b0;
    logic         ready;
    logic [255:0] rd;
    logic         valid, err;

    line_mem_ctrl #(.MEM_RANGE(256), .RD_LAT(RD_LAT), .QDEPTH(4)) dut (
        .master_clk (master_clk),
        .reset      (reset),
        .a          (a),
        .read       (read),
        .write      (write),
        .wd         (wd),
        .be         (be),
        .bypass     (bypass),
        .ready      (ready),
        .rd         (rd),
        .valid      (valid),
        .err        (err)
    );

    always #5 master_clk = ~master_clk;

    int cyc = 0;
    always @(posedge master_clk) cyc <= cyc + 1;

    typedef struct {
        logic [255:0] rd;
        logic         err;
        int           cyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   exp_err_only = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: every valid pops one expected read; a lone err must have been announced.
    always @(negedge master_clk) begin
        exp_t e;
        if (!reset) begin
            if (valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_valid");
                else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_rd"}, rd, e.rd);
                    chk({e.name, "_err"}, 256'(err), 256'(e.err));
                    if (e.cyc >= 0) chk({e.name, "_lat"}, 256'(cyc), 256'(e.cyc));
                end
            end else if (err) begin
                if (exp_err_only == 0) fail_now("unexpected_err");
                else exp_err_only--;
            end
        end
    end

    task automatic issue(input logic r, input logic w, input logic [31:0] ad, input logic [255:0] d,
                         input logic [3:0] b, input logic byp, output bit acc, output int acc_cyc);
        @(negedge master_clk);
        read = r; write = w; a = ad; wd = d; be = b; bypass = byp;
        acc = ready;
        acc_cyc = cyc + 1;
        @(posedge master_clk);
    endtask

    task automatic idle_in();
        @(negedge master_clk);
        read = 1'b0; write = 1'b0; bypass = 1'b0; be = '0;
    endtask

    task automatic wr_line(input string name, input logic [31:0] ad, input logic [255:0] d);
        bit acc; int c;
        issue(1'b0, 1'b1, ad, d, 4'h0, 1'b0, acc, c);
        chk({name, "_acc"}, 256'(acc), 256'(1));
    endtask

    task automatic rd_line(input string name, input logic [31:0] ad, input logic [255:0] exp_rd,
                           input logic exp_e, input bit lat);
        bit acc; int c;
        issue(1'b1, 1'b0, ad, '0, 4'h0, 1'b0, acc, c);
        chk({name, "_acc"}, 256'(acc), 256'(1));
        if (acc) exp_q.push_back('{exp_rd, exp_e, lat ? c + RD_LAT : -1, name});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge master_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now({name, "_timeout"});
            exp_q.delete();
        end
        repeat (6) @(posedge master_clk);
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_ready"}, 256'(ready), 256'(1));
        chk({name, "_valid"}, 256'(valid), 256'(0));
        chk({name, "_err"},   256'(err),   256'(0));
        chk({name, "_rd"},    rd,          256'(0));
    endtask

    localparam logic [255:0] L3  = {8{32'hA5A5_0003}};
    localparam logic [255:0] L0  = {8{32'h0000_00AA}};
    localparam logic [255:0] L7  = {8{32'h7777_0007}};
    localparam logic [255:0] BYP = {128'b0, 32'h0022_0044, 96'b0};

    initial begin
        bit acc; int c;

        // Reset state
        repeat (3) @(posedge master_clk);
        @(negedge master_clk) reset = 1'b0;
        @(posedge master_clk);
        @(negedge master_clk);
        check_reset_state("por");

        // Write then read line 3 with exact latency
        wr_line("w3", 32'h60, L3);
        idle_in();
        repeat (6) @(posedge master_clk);
        rd_line("r3", 32'h60, L3, 1'b0, 1'b1);
        idle_in();
        drain("t1");

        // Back-to-back reads fill the queue; the fifth is ignored
        for (int i = 0; i < 4; i++) wr_line("wfill", 32'((10 + i) << 5), {8{32'hD000_0000 + 32'(i)}});
        idle_in();
        repeat (12) @(posedge master_clk);
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b0, 32'((10 + i) << 5), '0, 4'h0, 1'b0, acc, c);
            if (i < 4) begin
                chk("b2b_acc", 256'(acc), 256'(1));
                if (acc) exp_q.push_back('{{8{32'hD000_0000 + 32'(i)}}, 1'b0, (i == 0) ? c + RD_LAT : -1, "b2b"});
            end else begin
                chk("b2b_fifth_ignored", 256'(acc), 256'(0));
            end
        end
        idle_in();
        drain("t2");

        // Bypass byte-masked word write
        wr_line("w1z", 32'h20, '0);
        issue(1'b0, 1'b1, 32'h2C, {224'b0, 32'h1122_3344}, 4'b0101, 1'b1, acc, c);
        chk("byp_acc", 256'(acc), 256'(1));
        idle_in();
        rd_line("byp", 32'h20, BYP, 1'b0, 1'b0);
        idle_in();
        drain("t3");

        // Out-of-range reads and write
        wr_line("w0", 32'h0, L0);
        idle_in();
        repeat (6) @(posedge master_clk);
        rd_line("oor_idx", 32'h0000_2000, '0, 1'b1, 1'b0);
        rd_line("oor_hi", 32'h8000_0060, '0, 1'b1, 1'b0);
        exp_err_only++;
        wr_line("oor_w", 32'h0000_2000, '1);
        rd_line("r0_kept", 32'h0, L0, 1'b0, 1'b0);
        idle_in();
        drain("t4");

        // Read and write in the same cycle act as a write plus err
        exp_err_only++;
        issue(1'b1, 1'b1, 32'hE0, L7, 4'h0, 1'b0, acc, c);
        chk("rw_acc", 256'(acc), 256'(1));
        idle_in();
        rd_line("r7", 32'hE0, L7, 1'b0, 1'b0);
        idle_in();
        drain("t5");

        // Reset while a read waits: no response, clean outputs afterwards
        issue(1'b1, 1'b0, 32'h60, '0, 4'h0, 1'b0, acc, c);
        chk("rst_rd_acc", 256'(acc), 256'(1));
        idle_in();
        @(posedge master_clk);
        @(negedge master_clk) reset = 1'b1;
        repeat (2) @(posedge master_clk);
        @(negedge master_clk) reset = 1'b0;
        @(posedge master_clk);
        @(negedge master_clk);
        check_reset_state("midrst");
        repeat (10) @(posedge master_clk);
        rd_line("r3_after_rst", 32'h60, L3, 1'b0, 1'b1);
        idle_in();
        drain("t6");

        chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        chk("err_only_consumed", 256'(exp_err_only), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
